// File: rtl/goofy_alu_pkg.sv
// goofy_pkg: shared definitions for the Goofy 8-bit CPU ALU.
//   GOOFY_WIDTH - default datapath width.
//   op_e        - operation select driven into goofy_alu_core.
//   op_select   - fixed-priority encoder from the one-hot-ish operation
//                 strobes to op_e (add > add_ov > sub > sub_ov > and > or > not).
package goofy_pkg;

  localparam int unsigned GOOFY_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_ADD_OV,
    OP_SUB,
    OP_SUB_OV,
    OP_AND,
    OP_OR,
    OP_NOT,
    OP_NONE
  } op_e;

  function automatic op_e op_select(
    input logic add,
    input logic add_ov,
    input logic sub,
    input logic sub_ov,
    input logic and_op,
    input logic or_op,
    input logic not_op
  );
    op_e sel;
    sel = OP_NONE;
    if (add)         sel = OP_ADD;
    else if (add_ov) sel = OP_ADD_OV;
    else if (sub)    sel = OP_SUB;
    else if (sub_ov) sel = OP_SUB_OV;
    else if (and_op) sel = OP_AND;
    else if (or_op)  sel = OP_OR;
    else if (not_op) sel = OP_NOT;
    return sel;
  endfunction

endpackage

// File: rtl/goofy_alu_core.sv
// goofy_alu_core: purely combinational arithmetic/logic unit.
//   a, b     - operands
//   ov_in    - current overflow/carry flag (carry-in / borrow-in for *_ov ops)
//   op       - operation select
//   result   - WIDTH-bit result (modulo 2^WIDTH)
//   ov_next  - new overflow flag; equals ov_in for ops that leave it alone
module goofy_alu_core
  import goofy_pkg::*;
#(
  parameter int unsigned WIDTH = GOOFY_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ov_in,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             ov_next
);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] ov_ext;

  assign ov_ext = {{WIDTH{1'b0}}, ov_in};

  always_comb begin
    result  = '0;
    ov_next = ov_in;
    ext     = '0;
    case (op)
      OP_ADD:    result = a + b;
      OP_ADD_OV: begin
        ext     = {1'b0, a} + {1'b0, b} + ov_ext;
        result  = ext[WIDTH-1:0];
        ov_next = ext[WIDTH];
      end
      OP_SUB:    result = a - b;
      OP_SUB_OV: begin
        // Top bit of the (WIDTH+1)-bit difference is set exactly when a < b + ov_in.
        ext     = {1'b0, a} - {1'b0, b} - ov_ext;
        result  = ext[WIDTH-1:0];
        ov_next = ext[WIDTH];
      end
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_NOT:    result = ~a;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/goofy_alu.sv
// goofy_alu: register-based ALU of the Goofy 8-bit CPU.
//   clk, res            - clock, synchronous active-high reset
//   alu0w/alu0d/alu0o   - operand A load strobe, data, current value
//   alu1w/alu1d/alu1o   - operand B load strobe, data, current value
//   alu_add..alu_not    - operation strobes (fixed priority if several)
//   alu_cmp             - eq <= (A == B)
//   alu_hlt             - set sticky halt flag
//   alu_flag_res        - clear ov and eq (wins over any update)
//   alu_out             - registered result
//   alu_flag_*_o        - overflow, equal, halt flags
// Optional: define GOOFY_ALU_ZERO_EQ_EN to make every operation also set
// eq <= (result == 0); a coincident alu_cmp takes priority over that.
module goofy_alu
  import goofy_pkg::*;
#(
  parameter int unsigned WIDTH = GOOFY_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             alu0w,
  input  logic [WIDTH-1:0] alu0d,
  output logic [WIDTH-1:0] alu0o,
  input  logic             alu1w,
  input  logic [WIDTH-1:0] alu1d,
  output logic [WIDTH-1:0] alu1o,
  input  logic             alu_add,
  input  logic             alu_add_ov,
  input  logic             alu_sub,
  input  logic             alu_sub_ov,
  input  logic             alu_and,
  input  logic             alu_or,
  input  logic             alu_not,
  input  logic             alu_cmp,
  input  logic             alu_hlt,
  input  logic             alu_flag_res,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_flag_ov_o,
  output logic             alu_flag_eq_o,
  output logic             alu_flag_hlt_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ov_q, ov_d;
  logic             eq_q, eq_d;
  logic             hlt_q, hlt_d;

  op_e              op_sel;
  logic [WIDTH-1:0] core_result;
  logic             core_ov_next;

  assign op_sel = op_select(alu_add, alu_add_ov, alu_sub, alu_sub_ov,
                            alu_and, alu_or, alu_not);

  // Core sees the registered operands, so a same-cycle load is not visible
  // to an operation until the following cycle.
  goofy_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a       (a_q),
    .b       (b_q),
    .ov_in   (ov_q),
    .op      (op_sel),
    .result  (core_result),
    .ov_next (core_ov_next)
  );

  always_comb begin
    a_d   = alu0w ? alu0d : a_q;
    b_d   = alu1w ? alu1d : b_q;
    out_d = out_q;
    ov_d  = ov_q;
    eq_d  = eq_q;
    hlt_d = hlt_q | alu_hlt;

    if (op_sel != OP_NONE) begin
      out_d = core_result;
      ov_d  = core_ov_next;
`ifdef GOOFY_ALU_ZERO_EQ_EN
      eq_d  = (core_result == '0);
`endif
    end

    if (alu_cmp) begin
      eq_d = (a_q == b_q);
    end

    if (alu_flag_res) begin
      ov_d = 1'b0;
      eq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
      eq_q  <= 1'b0;
      hlt_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      ov_q  <= ov_d;
      eq_q  <= eq_d;
      hlt_q <= hlt_d;
    end
  end

  assign alu0o          = a_q;
  assign alu1o          = b_q;
  assign alu_out        = out_q;
  assign alu_flag_ov_o  = ov_q;
  assign alu_flag_eq_o  = eq_q;
  assign alu_flag_hlt_o = hlt_q;

endmodule

// File: tb/tb_goofy_alu.sv
// tb_goofy_alu: directed table-driven bench for goofy_alu (default build,
// zero-eq option disabled). Each table row is one clock cycle of inputs
// followed by the register state expected after that edge.
module tb_goofy_alu;

  logic       clk = 1'b0;
  logic       res;
  logic       alu0w, alu1w;
  logic [7:0] alu0d, alu1d;
  logic [7:0] alu0o, alu1o, alu_out;
  logic       alu_add, alu_add_ov, alu_sub, alu_sub_ov, alu_and, alu_or, alu_not;
  logic       alu_cmp, alu_hlt, alu_flag_res;
  logic       alu_flag_ov_o, alu_flag_eq_o, alu_flag_hlt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  goofy_alu #(.WIDTH(8)) dut (
    .clk            (clk),
    .res            (res),
    .alu0w          (alu0w),
    .alu0d          (alu0d),
    .alu0o          (alu0o),
    .alu1w          (alu1w),
    .alu1d          (alu1d),
    .alu1o          (alu1o),
    .alu_add        (alu_add),
    .alu_add_ov     (alu_add_ov),
    .alu_sub        (alu_sub),
    .alu_sub_ov     (alu_sub_ov),
    .alu_and        (alu_and),
    .alu_or         (alu_or),
    .alu_not        (alu_not),
    .alu_cmp        (alu_cmp),
    .alu_hlt        (alu_hlt),
    .alu_flag_res   (alu_flag_res),
    .alu_out        (alu_out),
    .alu_flag_ov_o  (alu_flag_ov_o),
    .alu_flag_eq_o  (alu_flag_eq_o),
    .alu_flag_hlt_o (alu_flag_hlt_o)
  );

  // Operation strobe bits: {add, add_ov, sub, sub_ov, and, or, not}
  localparam logic [6:0] NOP   = 7'b0000000;
  localparam logic [6:0] ADD   = 7'b1000000;
  localparam logic [6:0] ADDOV = 7'b0100000;
  localparam logic [6:0] SUB   = 7'b0010000;
  localparam logic [6:0] SUBOV = 7'b0001000;
  localparam logic [6:0] LAND  = 7'b0000100;
  localparam logic [6:0] LOR   = 7'b0000010;
  localparam logic [6:0] LNOT  = 7'b0000001;

  typedef struct {
    logic       res;
    logic       ld0;
    logic [7:0] d0;
    logic       ld1;
    logic [7:0] d1;
    logic [6:0] ops;
    logic       cmp;
    logic       hlt;
    logic       fres;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] eo;
    logic       eov;
    logic       eeq;
    logic       ehlt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic r, input logic l0, input logic [7:0] d0,
    input logic l1, input logic [7:0] d1, input logic [6:0] ops,
    input logic cmp, input logic hlt, input logic fres,
    input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] eo,
    input logic eov, input logic eeq, input logic ehlt);
    vec_t v;
    v.res = r;   v.ld0 = l0;  v.d0 = d0;  v.ld1 = l1;  v.d1 = d1;
    v.ops = ops; v.cmp = cmp; v.hlt = hlt; v.fres = fres;
    v.ea = ea;   v.eb = eb;   v.eo = eo;
    v.eov = eov; v.eeq = eeq; v.ehlt = ehlt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    res = v.res;
    alu0w = v.ld0; alu0d = v.d0;
    alu1w = v.ld1; alu1d = v.d1;
    {alu_add, alu_add_ov, alu_sub, alu_sub_ov, alu_and, alu_or, alu_not} = v.ops;
    alu_cmp = v.cmp; alu_hlt = v.hlt; alu_flag_res = v.fres;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input vec_t v);
    chk({tag, " alu0o"},   alu0o,                 v.ea);
    chk({tag, " alu1o"},   alu1o,                 v.eb);
    chk({tag, " alu_out"}, alu_out,               v.eo);
    chk({tag, " ov"},      {7'd0, alu_flag_ov_o}, {7'd0, v.eov});
    chk({tag, " eq"},      {7'd0, alu_flag_eq_o}, {7'd0, v.eeq});
    chk({tag, " hlt"},     {7'd0, alu_flag_hlt_o},{7'd0, v.ehlt});
  endtask

  initial begin
    vec_t v;
    //                 res ld0 d0     ld1 d1     ops          cmp  hlt  fres  A      B      out    ov eq h
    vq.push_back(mk(1, 0, 8'h00, 0, 8'h00, ADD,         1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0)); // 0 reset wins
    vq.push_back(mk(0, 1, 8'h0A, 1, 8'h03, NOP,         0, 0, 0, 8'h0A, 8'h03, 8'h00, 0, 0, 0)); // 1
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, ADD,         0, 0, 0, 8'h0A, 8'h03, 8'h0D, 0, 0, 0)); // 2 add
    vq.push_back(mk(0, 1, 8'hFF, 1, 8'h01, NOP,         0, 0, 0, 8'hFF, 8'h01, 8'h0D, 0, 0, 0)); // 3
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, ADDOV,       0, 0, 0, 8'hFF, 8'h01, 8'h00, 1, 0, 0)); // 4 carry out
    vq.push_back(mk(0, 1, 8'h00, 1, 8'h00, NOP,         0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0)); // 5
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, ADDOV,       0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0)); // 6 carry in
    vq.push_back(mk(0, 1, 8'h05, 1, 8'h07, NOP,         0, 0, 0, 8'h05, 8'h07, 8'h01, 0, 0, 0)); // 7
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, SUBOV,       0, 0, 0, 8'h05, 8'h07, 8'hFE, 1, 0, 0)); // 8 borrow
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, NOP,         0, 0, 1, 8'h05, 8'h07, 8'hFE, 0, 0, 0)); // 9 flag_res
    vq.push_back(mk(0, 1, 8'h3C, 1, 8'h0F, NOP,         0, 0, 0, 8'h3C, 8'h0F, 8'hFE, 0, 0, 0)); // 10
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, LAND,        0, 0, 0, 8'h3C, 8'h0F, 8'h0C, 0, 0, 0)); // 11
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, LOR,         0, 0, 0, 8'h3C, 8'h0F, 8'h3F, 0, 0, 0)); // 12
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, LNOT,        0, 0, 0, 8'h3C, 8'h0F, 8'hC3, 0, 0, 0)); // 13
    vq.push_back(mk(0, 1, 8'h42, 1, 8'h42, NOP,         0, 0, 0, 8'h42, 8'h42, 8'hC3, 0, 0, 0)); // 14
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, NOP,         1, 0, 0, 8'h42, 8'h42, 8'hC3, 0, 1, 0)); // 15 cmp equal
    vq.push_back(mk(0, 0, 8'h00, 1, 8'h43, NOP,         1, 0, 0, 8'h42, 8'h43, 8'hC3, 0, 1, 0)); // 16 cmp uses old B
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, NOP,         1, 0, 0, 8'h42, 8'h43, 8'hC3, 0, 0, 0)); // 17
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, NOP,         0, 1, 0, 8'h42, 8'h43, 8'hC3, 0, 0, 1)); // 18 halt
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, NOP,         0, 0, 1, 8'h42, 8'h43, 8'hC3, 0, 0, 1)); // 19 halt sticky
    vq.push_back(mk(1, 0, 8'h00, 0, 8'h00, NOP,         0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0)); // 20 reset
    vq.push_back(mk(0, 1, 8'h80, 1, 8'h80, NOP,         0, 0, 0, 8'h80, 8'h80, 8'h00, 0, 0, 0)); // 21
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, ADDOV | SUB, 0, 0, 0, 8'h80, 8'h80, 8'h00, 1, 0, 0)); // 22 priority
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, ADDOV,       0, 0, 0, 8'h80, 8'h80, 8'h01, 1, 0, 0)); // 23 held add_ov
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, SUB,         0, 0, 0, 8'h80, 8'h80, 8'h00, 1, 0, 0)); // 24 sub keeps ov
    vq.push_back(mk(0, 1, 8'h10, 1, 8'h01, ADD,         0, 0, 0, 8'h10, 8'h01, 8'h00, 1, 0, 0)); // 25 op uses old A/B
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, ADDOV,       0, 0, 1, 8'h10, 8'h01, 8'h12, 0, 0, 0)); // 26 flag_res beats carry
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, SUBOV,       0, 0, 0, 8'h10, 8'h01, 8'h0F, 0, 0, 0)); // 27 no borrow
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, NOP,         0, 0, 0, 8'h10, 8'h01, 8'h0F, 0, 0, 0)); // 28 hold
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, ADD | LNOT,  0, 0, 0, 8'h10, 8'h01, 8'h11, 0, 0, 0)); // 29 priority
    vq.push_back(mk(0, 1, 8'h01, 0, 8'h00, NOP,         0, 0, 0, 8'h01, 8'h01, 8'h11, 0, 0, 0)); // 30
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, NOP,         1, 0, 1, 8'h01, 8'h01, 8'h11, 0, 0, 0)); // 31 flag_res beats cmp
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, NOP,         1, 0, 0, 8'h01, 8'h01, 8'h11, 0, 1, 0)); // 32
    vq.push_back(mk(0, 0, 8'h00, 0, 8'h00, SUBOV,       0, 0, 0, 8'h01, 8'h01, 8'h00, 0, 1, 0)); // 33 A==B, eq untouched
    vq.push_back(mk(1, 1, 8'h55, 1, 8'h66, LNOT,        0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0)); // 34 reset over all

    drive(mk(1, 0, 8'h00, 0, 8'h00, NOP, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    @(negedge clk);

    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      chk_state($sformatf("v%0d", i), vq[i]);
    end

    // Load A=B=FF, then hold add_ov high for three cycles; inputs are also
    // changed mid-cycle to show outputs only move on the clock edge.
    v = mk(0, 1, 8'hFF, 1, 8'hFF, NOP, 0, 0, 0, 8'hFF, 8'hFF, 8'h00, 0, 0, 0);
    drive(v);
    @(posedge clk); #1;
    chk_state("seq load", v);

    v = mk(0, 0, 8'h00, 0, 8'h00, ADDOV, 0, 1, 1, 8'hFF, 8'hFF, 8'h00, 0, 0, 0);
    drive(v);
    alu0w = 1'b1; alu0d = 8'h00; res = 1'b0;
    #2;
    chk_state("seq no comb path", v);
    alu0w = 1'b0; alu_hlt = 1'b0; alu_flag_res = 1'b0;

    @(posedge clk); #1;
    chk_state("seq acc1", mk(0, 0, 0, 0, 0, NOP, 0, 0, 0, 8'hFF, 8'hFF, 8'hFE, 1, 0, 0));
    @(posedge clk); #1;
    chk_state("seq acc2", mk(0, 0, 0, 0, 0, NOP, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0));
    @(posedge clk); #1;
    chk_state("seq acc3", mk(0, 0, 0, 0, 0, NOP, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
